// File: rtl/priority_decoder_collector.sv
// ---------------------------------------------------------------------------
// priority_decoder_collector
//
// Sequential inverse of a priority encoder. A stream of encoded indices
// (one per beat, framed by enc_lst) is turned back into a bit vector by
// OR-ing a one-hot bit per beat into an accumulator. When the last beat of
// a frame is accepted, the vector, the beat count and an out-of-range error
// flag are presented on the output handshake.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   enc_vld  in   input beat valid
//   enc_rdy  out  input beat ready (depends only on state and dec_rdy)
//   enc_idx  in   encoded index, WIDTH_LOG bits
//   enc_ena  in   index meaningful (0 = empty beat)
//   enc_lst  in   last beat of frame
//   dec_vld  out  output vector valid
//   dec_rdy  in   output vector ready
//   dec_vec  out  reconstructed vector, WIDTH bits
//   dec_cnt  out  beats in the frame, saturating, CNT_WIDTH bits
//   dec_err  out  frame had an enabled beat with enc_idx >= WIDTH
// ---------------------------------------------------------------------------
module priority_decoder_collector #(
    parameter  int WIDTH     = 16,
    parameter  int CNT_WIDTH = 8,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_vld,
    output logic                 enc_rdy,
    input  logic [WIDTH_LOG-1:0] enc_idx,
    input  logic                 enc_ena,
    input  logic                 enc_lst,
    output logic                 dec_vld,
    input  logic                 dec_rdy,
    output logic [WIDTH-1:0]     dec_vec,
    output logic [CNT_WIDTH-1:0] dec_cnt,
    output logic                 dec_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_acc;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_err;
    logic [WIDTH-1:0]       r_dec_vec;
    logic [CNT_WIDTH-1:0]   r_dec_cnt;
    logic                   r_dec_err;

    logic [WIDTH-1:0]       w_onehot;
    logic                   w_oob;
    logic                   w_enc_rdy;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic [WIDTH-1:0]       w_acc_upd;
    logic [CNT_WIDTH-1:0]   w_cnt_upd;
    logic                   w_err_upd;

    // One-hot decode of the incoming index. An index >= WIDTH matches no
    // position, so the vector is all zeros for it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
            assign w_onehot[gi] = enc_ena & (enc_idx == WIDTH_LOG'(gi));
        end
    endgenerate

    // An enabled beat that lit no bit must have been out of range.
    assign w_oob      = enc_ena & ~(|w_onehot);

    // In HOLD a new beat may only enter when the held result leaves in the
    // same cycle, which gives one beat per cycle without a bubble.
    assign w_enc_rdy  = (r_state == COLLECT) | dec_rdy;
    assign w_in_xfer  = enc_vld & w_enc_rdy;
    assign w_out_xfer = (r_state == HOLD) & dec_rdy;

    // The accumulator is cleared at frame end, so the same update serves
    // both a frame in progress and the first beat of a fresh frame in HOLD.
    assign w_acc_upd  = r_acc | w_onehot;
    assign w_cnt_upd  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_err_upd  = r_err | w_oob;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= COLLECT;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_dec_vec <= '0;
            r_dec_cnt <= '0;
            r_dec_err <= 1'b0;
        end else if (w_in_xfer && enc_lst) begin
            // Frame complete: publish including this beat, start afresh.
            r_dec_vec <= w_acc_upd;
            r_dec_cnt <= w_cnt_upd;
            r_dec_err <= w_err_upd;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_state   <= HOLD;
        end else begin
            if (w_in_xfer) begin
                r_acc <= w_acc_upd;
                r_cnt <= w_cnt_upd;
                r_err <= w_err_upd;
            end
            if (w_out_xfer) begin
                r_state <= COLLECT;
            end
        end
    end

    assign enc_rdy = w_enc_rdy;
    assign dec_vld = (r_state == HOLD);
    assign dec_vec = r_dec_vec;
    assign dec_cnt = r_dec_cnt;
    assign dec_err = r_dec_err;

endmodule
